// File: rtl/intersection_pkg.sv
// Shared phase encoding, lamp-vector layout and default durations for the
// intersection controller and the per-road light logic.
package intersection_pkg;

    localparam logic [2:0] PhMainGreen  = 3'd0;
    localparam logic [2:0] PhMainYellow = 3'd1;
    localparam logic [2:0] PhAllRed     = 3'd2;
    localparam logic [2:0] PhSideGreen  = 3'd3;
    localparam logic [2:0] PhSideYellow = 3'd4;
    localparam logic [2:0] PhPedWalk    = 3'd5;

    typedef enum logic [2:0] {
        StMainGreen  = PhMainGreen,
        StMainYellow = PhMainYellow,
        StAllRed     = PhAllRed,
        StSideGreen  = PhSideGreen,
        StSideYellow = PhSideYellow,
        StPedWalk    = PhPedWalk
    } phase_e;

    // Per-road lamp vector is {R, G, Y}.
    typedef logic [2:0] lamp_t;
    localparam int unsigned LampR = 2;
    localparam int unsigned LampG = 1;
    localparam int unsigned LampY = 0;
    localparam lamp_t LampRed    = 3'b100;
    localparam lamp_t LampGreen  = 3'b010;
    localparam lamp_t LampYellow = 3'b001;

    localparam int unsigned DefCw       = 12;
    localparam int unsigned DefGreenMin = 1024;
    localparam int unsigned DefSideT    = 512;
    localparam int unsigned DefYellowT  = 256;
    localparam int unsigned DefAllredT  = 64;
    localparam int unsigned DefPedT     = 384;

endpackage

// File: rtl/phase_timer.sv
// Shared phase timer: cleared on state entry, otherwise counts up, optionally
// holding at a saturation value.
module phase_timer #(
    parameter int unsigned CW = 12
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          sat_en,
    input  logic [CW-1:0] sat_val,
    output logic [CW-1:0] tmr
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tmr <= '0;
        end else if (clr) begin
            tmr <= '0;
        end else if (!(sat_en && tmr == sat_val)) begin
            tmr <= tmr + 1'b1;
        end
    end

endmodule

// File: rtl/intersection_scheduler.sv
// Two-road intersection phase scheduler: main road rests on green, side road
// and pedestrians are served on request with all-red clearance in between.
module intersection_scheduler
    import intersection_pkg::*;
#(
    parameter int unsigned CW        = DefCw,
    parameter int unsigned GREEN_MIN = DefGreenMin,
    parameter int unsigned SIDE_T    = DefSideT,
    parameter int unsigned YELLOW_T  = DefYellowT,
    parameter int unsigned ALLRED_T  = DefAllredT,
    parameter int unsigned PED_T     = DefPedT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       side_req,
    input  logic       ped_req,
    output logic       main_R,
    output logic       main_G,
    output logic       main_Y,
    output logic       side_R,
    output logic       side_G,
    output logic       side_Y,
    output logic       walk,
    output logic       ped_wait,
    output logic [2:0] phase
);

    localparam logic [CW-1:0] GreenLast  = CW'(GREEN_MIN - 1);
    localparam logic [CW-1:0] SideLast   = CW'(SIDE_T - 1);
    localparam logic [CW-1:0] YellowLast = CW'(YELLOW_T - 1);
    localparam logic [CW-1:0] AllredLast = CW'(ALLRED_T - 1);
    localparam logic [CW-1:0] PedLast    = CW'(PED_T - 1);

    phase_e        state_q, state_d;
    phase_e        target_q, target_d;
    logic          ped_pending_q;
    logic          ped_any;
    logic          clr;
    logic          enter_walk;
    logic [CW-1:0] tmr;
    logic [6:0]    lamps_q;

    // {main lamps, side lamps, walk}
    function automatic logic [6:0] lamps_of(input phase_e s);
        case (s)
            StMainGreen:  lamps_of = {LampGreen,  LampRed,    1'b0};
            StMainYellow: lamps_of = {LampYellow, LampRed,    1'b0};
            StSideGreen:  lamps_of = {LampRed,    LampGreen,  1'b0};
            StSideYellow: lamps_of = {LampRed,    LampYellow, 1'b0};
            StAllRed:     lamps_of = {LampRed,    LampRed,    1'b0};
            StPedWalk:    lamps_of = {LampRed,    LampRed,    1'b1};
            default:      lamps_of = {LampGreen,  LampRed,    1'b0};
        endcase
    endfunction

    phase_timer #(
        .CW(CW)
    ) u_timer (
        .clk     (clk),
        .rst     (rst),
        .clr     (clr),
        .sat_en  (state_q == StMainGreen),
        .sat_val (GreenLast),
        .tmr     (tmr)
    );

    // A request arriving this cycle counts as pending for every decision.
    assign ped_any = ped_pending_q | ped_req;

    always_comb begin
        state_d  = state_q;
        target_d = target_q;
        case (state_q)
            StMainGreen: begin
                if (tmr == GreenLast && (side_req || ped_any)) state_d = StMainYellow;
            end
            StMainYellow: begin
                if (tmr == YellowLast) begin
                    state_d  = StAllRed;
                    target_d = ped_any ? StPedWalk : StSideGreen;
                end
            end
            StSideGreen: begin
                if (tmr == SideLast) state_d = StSideYellow;
            end
            StSideYellow: begin
                if (tmr == YellowLast) begin
                    state_d  = StAllRed;
                    target_d = ped_any ? StPedWalk : StMainGreen;
                end
            end
            StPedWalk: begin
                if (tmr == PedLast) begin
                    state_d  = StAllRed;
                    target_d = side_req ? StSideGreen : StMainGreen;
                end
            end
            StAllRed: begin
                if (tmr == AllredLast) state_d = target_q;
            end
            default: state_d = StMainGreen;
        endcase
    end

    assign clr        = (state_d != state_q);
    assign enter_walk = (state_d == StPedWalk) && (state_q != StPedWalk);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= StMainGreen;
            target_q      <= StMainGreen;
            ped_pending_q <= 1'b0;
            lamps_q       <= lamps_of(StMainGreen);
        end else begin
            state_q       <= state_d;
            target_q      <= target_d;
            // Set wins over the clear on walk entry.
            ped_pending_q <= ped_req | (ped_pending_q & ~enter_walk);
            lamps_q       <= lamps_of(state_d);
        end
    end

    assign {main_R, main_G, main_Y} = lamps_q[6:4];
    assign {side_R, side_G, side_Y} = lamps_q[3:1];
    assign walk                     = lamps_q[0];
    assign ped_wait                 = ped_pending_q;
    assign phase                    = state_q;

endmodule
